// File: rtl/neopixel_pkg.sv
// Shared constants for the NeoPixel frame buffer and transmitter.
package neopixel_pkg;
  localparam int COLOR_W         = 24;
  localparam int DEF_N_PIX       = 18;
  localparam int DEF_RESET_SLOTS = 14;

  localparam logic MSG_PIXEL = 1'b1;
  localparam logic MSG_LATCH = 1'b0;
endpackage

// File: rtl/neopixel_slot_seq.sv
// Slot sequencer: two rd_next pulses per message, pixel slots then latch slots.
module neopixel_slot_seq #(
  parameter int N_PIX       = 18,
  parameter int RESET_SLOTS = 14,
  parameter int POS_W       = $clog2(N_PIX + RESET_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_next,
  output logic [POS_W-1:0] pos_o,
  output logic             wrap_o,
  output logic             frame_start_o
);
  localparam logic [POS_W-1:0] LAST  = POS_W'(N_PIX + RESET_SLOTS - 1);
  localparam logic [POS_W-1:0] START = POS_W'(N_PIX);

  logic [POS_W-1:0] pos_q;
  logic             phase_q;
  logic             frame_start_q;

  assign wrap_o        = rd_next && phase_q && (pos_q == LAST);
  assign pos_o         = pos_q;
  assign frame_start_o = frame_start_q;

  // Out of reset the sequencer sits in the first latch slot, so a full latch
  // period always precedes the first frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q         <= START;
      phase_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= wrap_o;
      if (rd_next) begin
        phase_q <= ~phase_q;
        if (phase_q) pos_q <= wrap_o ? '0 : pos_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/neopixel_frame_buf.sv
// Double-buffered pixel store; back bank is published to the front bank only at a frame wrap.
module neopixel_frame_buf
  import neopixel_pkg::*;
#(
  parameter int N_PIX       = DEF_N_PIX,
  parameter int RESET_SLOTS = DEF_RESET_SLOTS,
  parameter int ADDR_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               commit,
  output logic               commit_pending,
  input  logic               rd_next,
  output logic [COLOR_W-1:0] neo_dIn,
  output logic               rgb_msgTyp,
  output logic               frame_start
);
  localparam int POS_W = $clog2(N_PIX + RESET_SLOTS);

  logic [N_PIX-1:0][COLOR_W-1:0] front_q, back_q;
  logic                          pending_q;
  logic [POS_W-1:0]              pos;
  logic                          wrap;
  logic                          is_pix;

  neopixel_slot_seq #(
    .N_PIX      (N_PIX),
    .RESET_SLOTS(RESET_SLOTS),
    .POS_W      (POS_W)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .rd_next      (rd_next),
    .pos_o        (pos),
    .wrap_o       (wrap),
    .frame_start_o(frame_start)
  );

  // Copy uses the registered back bank, so a write in the wrap cycle waits
  // for the next commit. A commit arriving on the wrap itself is deferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q   <= '0;
      back_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        front_q   <= back_q;
        pending_q <= 1'b0;
      end else if (commit) begin
        pending_q <= 1'b1;
      end
      if (wr_en && (wr_addr < ADDR_W'(N_PIX))) back_q[wr_addr] <= wr_data;
    end
  end

  assign commit_pending = pending_q;
  assign is_pix         = (pos < POS_W'(N_PIX));
  assign rgb_msgTyp     = is_pix ? MSG_PIXEL : MSG_LATCH;
  assign neo_dIn        = is_pix ? front_q[pos] : '0;
endmodule

// File: tb/tb_neopixel_frame_buf.sv
// Randomized bench for neopixel_frame_buf against a half-message-count reference model.
module tb_neopixel_frame_buf;
  localparam int N_PIX = 18;
  localparam int RS    = 14;
  localparam int HALVES = 2 * (N_PIX + RS);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, commit = 1'b0, rd_next = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        commit_pending, rgb_msgTyp, frame_start;
  logic [23:0] neo_dIn;

  neopixel_frame_buf dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending), .rd_next(rd_next),
    .neo_dIn(neo_dIn), .rgb_msgTyp(rgb_msgTyp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: h counts rd_next pulses within a frame (two per message).
  logic [23:0] fm[N_PIX];
  logic [23:0] bm[N_PIX];
  bit          pend_m, fs_m;
  int          h;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (h=%0d)", tag, got, exp, h);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_PIX; i++) begin fm[i] = '0; bm[i] = '0; end
    pend_m = 0; fs_m = 0; h = 2 * N_PIX;
  endtask

  task automatic model_step();
    bit wrapm;
    wrapm = rd_next && (h == HALVES - 1);
    fs_m  = wrapm;
    if (wrapm && pend_m) begin
      for (int i = 0; i < N_PIX; i++) fm[i] = bm[i];
      pend_m = 0;
    end else if (commit) pend_m = 1;
    if (wr_en && wr_addr < N_PIX) bm[wr_addr] = wr_data;
    if (rd_next) h = (h + 1) % HALVES;
  endtask

  task automatic check_all();
    int p;
    p = h / 2;
    chk("msgTyp", 32'(rgb_msgTyp), 32'(p < N_PIX));
    if (p < N_PIX) chk("dIn_pix", 32'(neo_dIn), 32'(fm[p]));
    else           chk("dIn_latch", 32'(neo_dIn), 32'h0);
    chk("pending", 32'(commit_pending), 32'(pend_m));
    chk("frame_start", 32'(frame_start), 32'(fs_m));
  endtask

  // Inputs are set after a negedge; the model steps at the posedge and the
  // DUT is compared at the following negedge. Strobes are cleared afterwards.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    wr_en = 0; commit = 0;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 4 * HALVES && h != target; k++) step();
    chk("reach_h", 32'(h), 32'(target));
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_dIn", 32'(neo_dIn), 32'h0);
    chk("rst_pend", 32'(commit_pending), 32'h0);
    #2 rst = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Latch period out of reset, then frame_start and pixel 0.
    rd_next = 1;
    repeat (27) step();
    chk("fs_before28", 32'(frame_start), 32'h0);
    step();
    chk("fs_at28", 32'(frame_start), 32'h1);
    chk("typ_pix0", 32'(rgb_msgTyp), 32'h1);
    chk("dIn_pix0", 32'(neo_dIn), 32'h0);

    // Write without commit: nothing published.
    wr_en = 1; wr_addr = 5'd3; wr_data = 24'h660000;
    repeat (64) step();
    chk("nocommit_pend", 32'(commit_pending), 32'h0);

    // Commit mid-frame, published at the next wrap.
    run_to(20);
    commit = 1;
    step();
    chk("commit_pend", 32'(commit_pending), 32'h1);
    run_to(7);
    chk("pix3_new", 32'(neo_dIn), 32'h660000);
    chk("commit_clr", 32'(commit_pending), 32'h0);

    // Commit on the exact wrap cycle: deferred one frame.
    wr_en = 1; wr_addr = 5'd5; wr_data = 24'h123456;
    step();
    run_to(HALVES - 1);
    commit = 1;
    step();
    chk("wrapcommit_pend", 32'(commit_pending), 32'h1);
    run_to(11);
    chk("wrapcommit_old", 32'(neo_dIn), 32'h0);
    run_to(11 + 0 * HALVES + 1);
    run_to(10);
    chk("wrapcommit_new", 32'(neo_dIn), 32'h123456);

    // Out-of-range write is ignored.
    wr_en = 1; wr_addr = 5'd20; wr_data = 24'hFFFFFF;
    commit = 1;
    step();
    repeat (2 * HALVES) step();

    // Reset at pos 7 with a commit pending.
    run_to(14);
    wr_en = 1; wr_addr = 5'd0; wr_data = 24'hABCDEF; commit = 1;
    step();
    do_reset();
    rd_next = 1;
    repeat (28) step();
    chk("post_rst_fs", 32'(frame_start), 32'h1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      rd_next = ($urandom_range(0, 3) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 24'($urandom);
      commit  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/neopixel_frame_buf.md
Name: neopixel_frame_buf

Overview:
- Double-buffered pixel colour store that feeds the NeoPixel transmitter FSM (`neopixel_tx_fsm`) directly upstream of it.
- Host logic writes individual pixel colours into a back bank; a commit request copies the back bank to the front bank only at a frame boundary, so no frame is ever transmitted torn.
- A read sequencer answers the transmitter's `rd_next` strobes, presents one 24-bit colour per message, and inserts the latch (reset) message slots after the last pixel.

Parameters:
- N_PIX, 18, number of pixels in the chain.
- RESET_SLOTS, 14, number of latch messages sent after the last pixel of each frame.
- ADDR_W, 5, width of `wr_addr`.
- POS_W, $clog2(N_PIX+RESET_SLOTS), width of the slot counter (derived; do not override).

Ports:
- clk  input  1  system clock (internal oscillator domain).
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for the back bank.
- wr_addr  input  ADDR_W  pixel index to write.
- wr_data  input  24  pixel colour, GRB order as the transmitter expects.
- commit  input  1  single-cycle request to publish the back bank.
- commit_pending  output  1  a commit is queued and waiting for the frame boundary.
- rd_next  input  1  strobe from the transmitter: advance the read sequencer.
- neo_dIn  output  24  colour for the current message; 0 in latch slots.
- rgb_msgTyp  output  1  1 = pixel message, 0 = latch message.
- frame_start  output  1  one-cycle pulse when the sequencer wraps to pixel 0.

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous and active-low; all state clears immediately on assertion.
- Reset values:
  - front and back banks all zero.
  - `commit_pending`=0, `frame_start`=0.
  - sequencer pos=N_PIX, phase=0, so output starts in the first latch slot.
  - `rgb_msgTyp`=0, `neo_dIn`=0.
- Sequencer state: pos in 0..N_PIX+RESET_SLOTS-1, plus a 1-bit phase. Each message spans two `rd_next` pulses.
  - `rd_next` with phase=0: phase becomes 1; pos unchanged.
  - `rd_next` with phase=1: phase becomes 0 and pos increments.
  - From pos=N_PIX+RESET_SLOTS-1, pos wraps to 0. On that wrap, `frame_start` is high for the following cycle.
- Output decode:
  - `rgb_msgTyp` = (pos < N_PIX).
  - `neo_dIn` = front[pos] when pos < N_PIX, else 24'h0.
  - Both are combinational from registered state only; no combinational path from any input. Valid in the cycle after the `rd_next` that changed pos.
- Writes:
  - `wr_en` with `wr_addr` < N_PIX writes `wr_data` to back[wr_addr], effective the next cycle.
  - `wr_addr` >= N_PIX: write ignored, no state change.
  - Writes never touch the front bank.
- Commit:
  - `commit` sets `commit_pending`. `commit` while already pending has no additional effect.
  - On the wrap cycle with `commit_pending`=1: front <= back (the registered value, excluding any same-cycle write), and `commit_pending` clears. The back bank retains its contents, so later partial updates work.
  - `commit` asserted in the same cycle as the wrap: not taken at this wrap. `commit_pending` becomes 1 and the copy happens at the next wrap.
  - `wr_en` in the same cycle as the copy: the write lands in back only and is published by the next commit.
- `rd_next` held high every cycle is legal: the sequencer advances one half-message per cycle with no throughput limit.
- Reset asserted mid-frame: banks cleared, pending commit dropped, sequencer returns to pos=N_PIX, phase=0. The next frame begins after a full latch period.

Decomposition:
- Shared package `neopixel_pkg`:
  - COLOR_W=24.
  - MSG_PIXEL=1'b1, MSG_LATCH=1'b0.
  - Default N_PIX and RESET_SLOTS constants, reused by the top level and the transmitter.
- One natural sub-module: `neopixel_slot_seq`.
  - Contains the pos/phase counter, wrap detect and `frame_start`.
  - Parameterised by N_PIX and RESET_SLOTS.
  - Bank registers and commit logic stay in `neopixel_frame_buf`.

Test Plan:
- Reset release, `rd_next` every cycle -> `rgb_msgTyp`=0 and `neo_dIn`=0 for 28 pulses. `frame_start` pulses after the 28th pulse; then `rgb_msgTyp`=1 with `neo_dIn`=24'h000000 at pos 0.
- Write back[3]=24'h660000 without commit, run a full frame (64 pulses) -> pos 3 still outputs 0 and `commit_pending` stays 0.
- Same write, then `commit` mid-frame -> `commit_pending`=1 until the wrap. In the next frame, pos 3 outputs 24'h660000 and all other pixels output 0; `commit_pending` returns to 0.
- `commit` on the exact wrap cycle -> the frame that starts shows old data; `commit_pending`=1; the following frame shows the new data.
- `wr_en` with `wr_addr`=20 and `wr_data`=24'hFFFFFF, then commit and run a frame -> all pixel outputs are unchanged.
- Assert `rst` at pos 7 with a commit pending -> all outputs 0 and `commit_pending`=0. After release, the first 28 pulses are latch slots, then pixels read 0.
